// File: rtl/gmii_frame_tx.sv
// GMII transmit framer: preamble/SFD, payload, optional zero pad (GMII_TX_PAD_EN), CRC32 FCS, IFG.
// Latency: byte accepted on one edge is on gmii_txd the next cycle; first payload byte PREAMBLE_LEN+2 cycles after tx_valid.
// Backpressure: tx_ready only in SFD/DATA; a missing byte while ready is an underrun that ends the frame with a bad FCS.
module gmii_frame_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;          // preamble / IFG cycle index
  logic [1:0]  fcs_idx, fcs_idx_nxt;
  logic [31:0] crc, crc_nxt;
  logic        underrun_q, underrun_nxt;
  logic        tx_ready_nxt, gmii_tx_en_nxt, tx_busy_nxt, tx_done_nxt, tx_underrun_nxt;
  logic [7:0]  gmii_txd_nxt, fcs_byte;
  logic        starve;

  assign starve = tx_ready & ~tx_valid;

`ifdef GMII_TX_PAD_EN
  localparam logic [15:0] MIN_CNT = 16'(MIN_FRAME);
  logic [15:0] byte_cnt, byte_cnt_nxt;
  logic        pad_short;
  assign pad_short = byte_cnt < MIN_CNT;
`endif

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      fcs_idx     <= 2'd0;
      crc         <= 32'hFFFFFFFF;
      underrun_q  <= 1'b0;
      tx_ready    <= 1'b0;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= 8'h00;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
`ifdef GMII_TX_PAD_EN
      byte_cnt    <= 16'd0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      fcs_idx     <= fcs_idx_nxt;
      crc         <= crc_nxt;
      underrun_q  <= underrun_nxt;
      tx_ready    <= tx_ready_nxt;
      gmii_tx_en  <= gmii_tx_en_nxt;
      gmii_txd    <= gmii_txd_nxt;
      tx_busy     <= tx_busy_nxt;
      tx_done     <= tx_done_nxt;
      tx_underrun <= tx_underrun_nxt;
`ifdef GMII_TX_PAD_EN
      byte_cnt    <= byte_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (tx_valid) state_nxt = S_PRE;
      S_PRE:  if (cnt == PRE_LAST) state_nxt = S_SFD;
      S_SFD, S_DATA: begin
        // tx_ready low in DATA means the tagged last byte is on the wire now
        if (tx_ready) begin
          state_nxt = tx_valid ? S_DATA : S_FCS;
        end else begin
`ifdef GMII_TX_PAD_EN
          state_nxt = pad_short ? S_PAD : S_FCS;
`else
          state_nxt = S_FCS;
`endif
        end
      end
`ifdef GMII_TX_PAD_EN
      S_PAD:  if (byte_cnt == MIN_CNT) state_nxt = S_FCS;
`endif
      S_FCS:  if (fcs_idx == 2'd3) state_nxt = S_IFG;
      S_IFG:  if (cnt == IFG_LAST) state_nxt = tx_valid ? S_PRE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt         = cnt;
    fcs_idx_nxt     = fcs_idx;
    crc_nxt         = crc;
    underrun_nxt    = underrun_q;
    tx_ready_nxt    = 1'b0;
    gmii_tx_en_nxt  = 1'b0;
    gmii_txd_nxt    = 8'h00;
    tx_busy_nxt     = (state_nxt != S_IDLE);
    tx_done_nxt     = 1'b0;
    tx_underrun_nxt = 1'b0;
    fcs_byte        = 8'h00;
`ifdef GMII_TX_PAD_EN
    byte_cnt_nxt    = byte_cnt;
`endif
    case (state_nxt)
      S_PRE: begin
        gmii_tx_en_nxt = 1'b1;
        gmii_txd_nxt   = 8'h55;
        cnt_nxt        = (state == S_PRE) ? cnt + 8'd1 : 8'd0;
        underrun_nxt   = 1'b0;
`ifdef GMII_TX_PAD_EN
        byte_cnt_nxt   = 16'd0;
`endif
      end
      S_SFD: begin
        gmii_tx_en_nxt = 1'b1;
        gmii_txd_nxt   = 8'hD5;
        tx_ready_nxt   = 1'b1;
      end
      S_DATA: begin
        gmii_tx_en_nxt = 1'b1;
        gmii_txd_nxt   = tx_data;
        tx_ready_nxt   = ~tx_last;
        crc_nxt        = crc_step(crc, tx_data);
`ifdef GMII_TX_PAD_EN
        byte_cnt_nxt   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
`endif
      end
`ifdef GMII_TX_PAD_EN
      S_PAD: begin
        gmii_tx_en_nxt = 1'b1;
        crc_nxt        = crc_step(crc, 8'h00);
        byte_cnt_nxt   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
      end
`endif
      S_FCS: begin
        gmii_tx_en_nxt = 1'b1;
        if (state == S_FCS) begin
          fcs_idx_nxt = fcs_idx + 2'd1;
        end else begin
          fcs_idx_nxt     = 2'd0;
          underrun_nxt    = starve;
          tx_underrun_nxt = starve;
        end
        // an underrun sends the uncomplemented CRC so the receiver rejects the frame
        fcs_byte     = crc[{fcs_idx_nxt, 3'b000} +: 8];
        gmii_txd_nxt = underrun_nxt ? fcs_byte : ~fcs_byte;
      end
      S_IFG: begin
        cnt_nxt     = (state == S_IFG) ? cnt + 8'd1 : 8'd0;
        crc_nxt     = 32'hFFFFFFFF;
        tx_done_nxt = (cnt_nxt == IFG_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for gmii_frame_tx: latency, FCS, padding, back-to-back IFG, underrun, mid-frame reset.
module tb_gmii_frame_tx;

  typedef logic [7:0] bq_t[$];

  logic       gmii_tx_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, gmii_tx_en, tx_busy, tx_done, tx_underrun;
  logic [7:0] gmii_txd;

  gmii_frame_tx dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // wire monitor
  bq_t cap, expq;
  int  gaps[$];
  int  cyc = 0, last_en_cyc = 0, low_run = 0, done_cnt = 0, und_cnt = 0, done_lat = 0;
  bit  prev_en = 1'b0, seen = 1'b0;

  always @(negedge gmii_tx_clk) begin
    cyc++;
    if (gmii_tx_en) begin
      if (!prev_en && seen) gaps.push_back(low_run);
      cap.push_back(gmii_txd);
      low_run     = 0;
      last_en_cyc = cyc;
      seen        = 1'b1;
    end else begin
      low_run++;
    end
    prev_en = gmii_tx_en;
    if (tx_done) begin
      done_cnt++;
      done_lat = cyc - last_en_cyc;
    end
    if (tx_underrun) und_cnt++;
  end

  function automatic logic [31:0] crc_reg(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic expect_frame(input bq_t pl, input bit under);
    bq_t body;
    logic [31:0] c, f;
    body = pl;
    repeat (7) expq.push_back(8'h55);
    expq.push_back(8'hD5);
`ifdef GMII_TX_PAD_EN
    if (!under) while (body.size() < 60) body.push_back(8'h00);
`endif
    foreach (body[i]) expq.push_back(body[i]);
    c = crc_reg(body);
    f = under ? c : ~c;
    for (int i = 0; i < 4; i++) expq.push_back(f[8*i +: 8]);
  endtask

  task automatic compare_cap(input string tag);
    check_eq({tag, "_len"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), cap[i], expq[i]);
    cap.delete();
    expq.delete();
  endtask

  task automatic send(input bq_t d, input bit mark_last);
    int idx;
    int guard;
    bit acc;
    idx   = 0;
    guard = 0;
    tx_valid = 1'b1;
    tx_data  = d[0];
    tx_last  = mark_last && (d.size() == 1);
    while (idx < d.size() && guard < 3000) begin
      @(negedge gmii_tx_clk);
      acc = tx_ready && tx_valid;
      @(posedge gmii_tx_clk);
      #1;
      guard++;
      if (acc) begin
        idx++;
        if (idx < d.size()) begin
          tx_data = d[idx];
          tx_last = mark_last && (idx == d.size() - 1);
        end
      end
    end
    if (idx < d.size()) check_eq("send_timeout", idx, d.size());
    tx_last = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int g;
    g = 0;
    while (done_cnt < n && g < 2000) begin
      @(posedge gmii_tx_clk);
      g++;
    end
    repeat (3) @(posedge gmii_tx_clk);
    check_eq("done_count", done_cnt, n);
  endtask

  task automatic digits_frame(input string tag, input int done_target);
    bq_t d;
    for (int i = 1; i <= 9; i++) d.push_back(8'(8'h30 + i));
    send(d, 1'b1);
    tx_valid = 1'b0;
    wait_done(done_target);
    check_eq({tag, "_ifg_to_done"}, done_lat, 12);
`ifndef GMII_TX_PAD_EN
    check_eq({tag, "_en_cycles"}, cap.size(), 21);
    check_eq({tag, "_fcs0"}, cap[17], 8'h26);
    check_eq({tag, "_fcs1"}, cap[18], 8'h39);
    check_eq({tag, "_fcs2"}, cap[19], 8'hF4);
    check_eq({tag, "_fcs3"}, cap[20], 8'hCB);
`else
    check_eq({tag, "_en_cycles"}, cap.size(), 72);
`endif
    expect_frame(d, 1'b0);
    compare_cap(tag);
  endtask

  initial begin
    bq_t f1, f2, d;

    repeat (3) @(posedge gmii_tx_clk);
    @(negedge gmii_tx_clk);
    check_eq("rst_en", gmii_tx_en, 0);
    check_eq("rst_txd", gmii_txd, 8'h00);
    check_eq("rst_ready", tx_ready, 0);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_done", tx_done, 0);
    check_eq("rst_underrun", tx_underrun, 0);
    @(posedge gmii_tx_clk);
    #1;
    rst = 1'b0;

    // latency from tx_valid to tx_en and first payload byte, alongside the "123456789" frame
    fork
      digits_frame("digits", 1);
      begin
        @(negedge gmii_tx_clk);
        check_eq("lat_en_before", gmii_tx_en, 0);
        @(negedge gmii_tx_clk);
        check_eq("lat_en_rise", gmii_tx_en, 1);
        check_eq("lat_pre0", gmii_txd, 8'h55);
        check_eq("lat_busy", tx_busy, 1);
        repeat (6) @(negedge gmii_tx_clk);
        check_eq("lat_pre6", gmii_txd, 8'h55);
        check_eq("lat_pre_ready", tx_ready, 0);
        @(negedge gmii_tx_clk);
        check_eq("lat_sfd", gmii_txd, 8'hD5);
        check_eq("lat_sfd_ready", tx_ready, 1);
        @(negedge gmii_tx_clk);
        check_eq("lat_first_byte", gmii_txd, 8'h31);
      end
    join
    @(negedge gmii_tx_clk);
    check_eq("idle_busy", tx_busy, 0);
    check_eq("idle_en", gmii_tx_en, 0);

    // single-byte payload
    d.delete();
    d.push_back(8'hAB);
    send(d, 1'b1);
    tx_valid = 1'b0;
    wait_done(2);
`ifdef GMII_TX_PAD_EN
    check_eq("short_en_cycles", cap.size(), 72);
`else
    check_eq("short_en_cycles", cap.size(), 13);
`endif
    expect_frame(d, 1'b0);
    compare_cap("short");

    // back-to-back 64-byte frames with tx_valid held
    gaps.delete();
    for (int i = 0; i < 64; i++) begin
      f1.push_back(8'(i));
      f2.push_back(8'(8'h80 + i));
    end
    send(f1, 1'b1);
    send(f2, 1'b1);
    tx_valid = 1'b0;
    wait_done(4);
    check_eq("b2b_gap_count", gaps.size(), 2);
    if (gaps.size() == 2) check_eq("b2b_gap", gaps[1], 12);
    expect_frame(f1, 1'b0);
    expect_frame(f2, 1'b0);
    compare_cap("b2b");

    // underrun after 20 bytes, then a clean frame
    d.delete();
    for (int i = 0; i < 20; i++) d.push_back(8'(3 * i + 1));
    send(d, 1'b0);
    tx_valid = 1'b0;
    wait_done(5);
    check_eq("underrun_pulses", und_cnt, 1);
    expect_frame(d, 1'b1);
    compare_cap("underrun");
    d.delete();
    for (int i = 0; i < 6; i++) d.push_back(8'(8'hC0 + i));
    send(d, 1'b1);
    tx_valid = 1'b0;
    wait_done(6);
    check_eq("post_underrun_pulses", und_cnt, 1);
    expect_frame(d, 1'b0);
    compare_cap("after_underrun");

    // reset while the 10th payload byte is on the wire
    tx_data  = 8'h5A;
    tx_last  = 1'b0;
    tx_valid = 1'b1;
    repeat (18) @(posedge gmii_tx_clk);
    @(negedge gmii_tx_clk);
    check_eq("prerst_txd", gmii_txd, 8'h5A);
    check_eq("prerst_ready", tx_ready, 1);
    rst = 1'b1;
    @(negedge gmii_tx_clk);
    check_eq("midrst_en", gmii_tx_en, 0);
    check_eq("midrst_txd", gmii_txd, 8'h00);
    check_eq("midrst_ready", tx_ready, 0);
    check_eq("midrst_busy", tx_busy, 0);
    @(posedge gmii_tx_clk);
    #1;
    rst      = 1'b0;
    tx_valid = 1'b0;
    cap.delete();
    digits_frame("after_rst", 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
